// File: rtl/pgm_rom_ddram_loader_if.sv
// Bus bundles for pgm_rom_ddram_loader.
// pgm_rom_ddram_loader_ioctl_if: HPS ioctl download port (master = HPS, slave = loader).
// pgm_rom_ddram_loader_ddram_if: single-beat DDRAM write port (master = loader, slave = controller).

interface pgm_rom_ddram_loader_ioctl_if;
    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned INDEX_W = 8;

    logic                ioctl_download;
    logic                ioctl_wr;
    logic [ADDR_W-1:0]   ioctl_addr;
    logic [DATA_W-1:0]   ioctl_dout;
    logic [INDEX_W-1:0]  ioctl_index;
    logic                ioctl_wait;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_wait
    );
endinterface

interface pgm_rom_ddram_loader_ddram_if;
    localparam int unsigned ADDR_W  = 29;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = 8;
    localparam int unsigned BURST_W = 4;

    logic                ddram_busy;
    logic                ddram_we;
    logic [ADDR_W-1:0]   ddram_addr;
    logic [DATA_W-1:0]   ddram_din;
    logic [BE_W-1:0]     ddram_be;
    logic [BURST_W-1:0]  ddram_burstcnt;

    modport master (
        output ddram_we, ddram_addr, ddram_din, ddram_be, ddram_burstcnt,
        input  ddram_busy
    );

    modport slave (
        input  ddram_we, ddram_addr, ddram_din, ddram_be, ddram_burstcnt,
        output ddram_busy
    );
endinterface

// File: rtl/pgm_rom_ddram_loader.sv
// pgm_rom_ddram_loader: packs 16-bit HPS ioctl download writes for one ROM index
// into 64-bit DDRAM words and issues single-beat writes with byte enables.
// Optional build macro PGM_LOADER_BSWAP_EN: byte-swap each 16-bit ioctl word
// before packing (68000 big-endian program ROMs). Undefined: data stored as-is.
//
// Storage: accumulator (partial word) -> output slot (ddram_* registers).
// A completed word that cannot enter the slot is held "full" in the accumulator
// and ioctl_wait is raised. If a new-tag write arrives in the very cycle the old
// word completes against a blocked slot, that one write is parked in a pending
// register and replayed into the accumulator when the held word moves out.

module pgm_rom_ddram_loader #(
    parameter logic [28:0] BASE_ADDR = 29'h0300000,
    parameter logic [7:0]  ROM_INDEX = 8'd1
) (
    input  logic                                clk,
    input  logic                                reset,
    pgm_rom_ddram_loader_ioctl_if.slave         ioctl,
    pgm_rom_ddram_loader_ddram_if.master        ddram,
    output logic                                load_done,
    output logic                                overrun
);

    localparam int unsigned TAG_W  = 24;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned BE_W   = 8;
    localparam int unsigned DADR_W = 29;

    typedef struct packed {
        logic               valid;
        logic               full;
        logic [TAG_W-1:0]   tag;
        logic [WORD_W-1:0]  data;
        logic [BE_W-1:0]    be;
    } acc_t;

    typedef struct packed {
        logic               valid;
        logic [LANE_W-1:0]  lane;
        logic [TAG_W-1:0]   tag;
        logic [HALF_W-1:0]  data;
    } pend_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH
    } state_t;

    localparam acc_t  ACC_EMPTY  = '0;
    localparam pend_t PEND_EMPTY = '0;

    // Drop one 16-bit half into its lane and mark its two byte enables.
    function automatic acc_t acc_put(input acc_t a, input logic [LANE_W-1:0] lane,
                                     input logic [HALF_W-1:0] d);
        acc_t r;
        r = a;
        r.valid = 1'b1;
        r.data[{lane, 4'b0000} +: HALF_W] = d;
        r.be[{lane, 1'b0} +: 2]           = 2'b11;
        return r;
    endfunction

    acc_t               acc_q, acc_n, fresh;
    pend_t              pend_q, pend_n;
    state_t             state_q, state_n;
    logic               dl_q;
    logic               wr_hit, accept, drop, dl_fall;
    logic               slot_take, slot_open;
    logic [LANE_W-1:0]  wr_lane;
    logic [TAG_W-1:0]   wr_tag;
    logic [HALF_W-1:0]  wr_data;
    logic               move_v;
    acc_t               move_w;
    logic               we_n, wait_n, done_n;
    logic [DADR_W-1:0]  addr_n;
    logic [WORD_W-1:0]  din_n;
    logic [BE_W-1:0]    be_n;
    logic               unused_addr_lsb;

    assign unused_addr_lsb      = ioctl.ioctl_addr[0];
    assign ddram.ddram_burstcnt = 4'd1;

    // Decode the incoming ioctl write.
    always_comb begin
        wr_hit  = ioctl.ioctl_download & ioctl.ioctl_wr & (ioctl.ioctl_index == ROM_INDEX);
        accept  = wr_hit & ~ioctl.ioctl_wait;
        drop    = wr_hit & ioctl.ioctl_wait;
        dl_fall = dl_q & ~ioctl.ioctl_download;
        wr_lane = ioctl.ioctl_addr[2:1];
        wr_tag  = ioctl.ioctl_addr[26:3];
`ifdef PGM_LOADER_BSWAP_EN
        wr_data = {ioctl.ioctl_dout[7:0], ioctl.ioctl_dout[15:8]};
`else
        wr_data = ioctl.ioctl_dout;
`endif
        slot_take = ddram.ddram_we & ~ddram.ddram_busy;
        slot_open = ~ddram.ddram_we | slot_take;
    end

    // Accumulator / pending / output-slot next state.
    always_comb begin
        acc_n  = acc_q;
        pend_n = pend_q;
        fresh  = ACC_EMPTY;
        move_v = 1'b0;
        move_w = ACC_EMPTY;
        we_n   = ddram.ddram_we & ~slot_take;
        addr_n = ddram.ddram_addr;
        din_n  = ddram.ddram_din;
        be_n   = ddram.ddram_be;

        if (acc_q.full) begin
            // Held word waits for the slot; replay any parked write behind it.
            move_v = 1'b1;
            move_w = acc_q;
            if (slot_open) begin
                acc_n  = ACC_EMPTY;
                pend_n = PEND_EMPTY;
                if (pend_q.valid) begin
                    fresh      = ACC_EMPTY;
                    fresh.tag  = pend_q.tag;
                    fresh      = acc_put(fresh, pend_q.lane, pend_q.data);
                    fresh.full = (pend_q.lane == 2'd3) | ~ioctl.ioctl_download;
                    acc_n      = fresh;
                end
            end
        end else begin
            // Tag change or end of download closes the current word.
            if (acc_q.valid && (dl_fall || (accept && (wr_tag != acc_q.tag)))) begin
                move_v = 1'b1;
                move_w = acc_q;
                acc_n  = ACC_EMPTY;
            end
            if (accept) begin
                fresh      = acc_n;
                fresh.tag  = wr_tag;
                fresh      = acc_put(fresh, wr_lane, wr_data);
                fresh.full = (wr_lane == 2'd3);
                acc_n      = fresh;
            end
            if (move_v) begin
                if (!slot_open) begin
                    acc_n      = acc_q;
                    acc_n.full = 1'b1;
                    if (accept) begin
                        pend_n.valid = 1'b1;
                        pend_n.lane  = wr_lane;
                        pend_n.tag   = wr_tag;
                        pend_n.data  = wr_data;
                    end
                end
            end else if (acc_n.full && slot_open) begin
                move_v = 1'b1;
                move_w = acc_n;
                acc_n  = ACC_EMPTY;
            end
        end

        if (move_v && slot_open) begin
            we_n   = 1'b1;
            addr_n = BASE_ADDR + DADR_W'(move_w.tag);
            din_n  = move_w.data;
            be_n   = move_w.be;
        end

        wait_n = acc_n.full;
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q            <= ACC_EMPTY;
            pend_q           <= PEND_EMPTY;
            dl_q             <= 1'b0;
            overrun          <= 1'b0;
            ioctl.ioctl_wait <= 1'b0;
            ddram.ddram_we   <= 1'b0;
            ddram.ddram_addr <= BASE_ADDR;
            ddram.ddram_din  <= '0;
            ddram.ddram_be   <= '0;
        end else begin
            acc_q            <= acc_n;
            pend_q           <= pend_n;
            dl_q             <= ioctl.ioctl_download;
            overrun          <= overrun | drop;
            ioctl.ioctl_wait <= wait_n;
            ddram.ddram_we   <= we_n;
            ddram.ddram_addr <= addr_n;
            ddram.ddram_din  <= din_n;
            ddram.ddram_be   <= be_n;
        end
    end

    // Completion tracker state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            load_done <= 1'b0;
        end else begin
            state_q   <= state_n;
            load_done <= done_n;
        end
    end

    // Completion tracker: pulse load_done once the download ended and all data drained.
    always_comb begin
        state_n = state_q;
        done_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_n = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (dl_fall) state_n = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (accept) begin
                    state_n = ST_ACTIVE;
                end else if (!acc_q.valid && !pend_q.valid && !ddram.ddram_we) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
